sram_responder: RTL and testbench

- Synthesizable model of the external 16-bit asynchronous SRAM chip. It answers the SRAM_* pin bus that our SRAM controller drives.
- Used in simulation and on-FPGA self-test in place of the physical chip. It closes the loop behind the controller so MEM-stage traffic can be checked end to end.
- Supports per-byte lane writes, configurable read latency for stress testing, tristated data pins, and access statistics.

---
 rtl/sram_responder.sv | 160 ++++++++++++++++
 tb/tb_sram_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: stand-in for the external 16-bit async SRAM, answering the controller's SRAM_* pins.
// Latency: writes land on the posedge; reads drive DQ after READ_LAT clocks (0 = combinational).
// Backpressure: none, the pin bus cannot stall. Optional reset-time clear sweep under SRAM_RESP_CLEAR_EN.
module sram_responder #(
    parameter int MEM_AW   = 10,
    parameter int READ_LAT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [17:0]      SRAM_ADDR,
    inout  wire  [15:0]      SRAM_DQ,
    input  logic             SRAM_UB_N,
    input  logic             SRAM_LB_N,
    input  logic             SRAM_WE_N,
    input  logic             SRAM_CE_N,
    input  logic             SRAM_OE_N,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic             addr_oob,
    output logic             init_busy
);

    localparam int DEPTH = 1 << MEM_AW;

    if (READ_LAT < 0 || READ_LAT > 3) begin : g_bad_lat
        $error("sram_responder: READ_LAT must be 0..3");
    end

    logic [15:0]       mem [DEPTH];
    logic [MEM_AW-1:0] idx;
    logic              addr_hi;
    logic              busy;
    logic              wr_cyc;
    logic              rd_cyc;
    logic              drv_base;
    logic              drv_ok;
    logic              drv_ub;
    logic              drv_lb;
    logic [15:0]       drv_data;
    logic [15:0]       rd_word;
    logic              clr_en;
    logic [MEM_AW-1:0] clr_idx;

    assign idx = SRAM_ADDR[MEM_AW-1:0];

    // Upper address bits alias onto the implemented array but are flagged.
    if (MEM_AW < 18) begin : g_hi
        assign addr_hi = |SRAM_ADDR[17:MEM_AW];
    end else begin : g_no_hi
        assign addr_hi = 1'b0;
    end

`ifdef SRAM_RESP_CLEAR_EN
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    state_t            state;
    state_t            state_nxt;
    logic [MEM_AW-1:0] sweep_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_CLEAR;
            sweep_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) sweep_idx <= sweep_idx + MEM_AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        clr_en    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (sweep_idx == {MEM_AW{1'b1}}) state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end

    assign clr_idx = sweep_idx;
`else
    assign clr_en  = 1'b0;
    assign clr_idx = '0;
`endif

    assign busy      = clr_en;
    assign init_busy = clr_en;

    assign wr_cyc   = ~SRAM_CE_N & ~SRAM_WE_N & ~busy;
    assign rd_cyc   = ~SRAM_CE_N &  SRAM_WE_N & ~busy;
    assign drv_base = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N & ~busy;
    assign rd_word  = mem[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            if (clr_en) begin
                mem[clr_idx] <= '0;
            end else if (wr_cyc) begin
                if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
                if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_count <= '0;
            rd_count <= '0;
            addr_oob <= 1'b0;
        end else begin
            if (wr_cyc) wr_count <= wr_count + CNT_W'(1);
            if (rd_cyc) rd_count <= rd_count + CNT_W'(1);
            if ((wr_cyc | rd_cyc) & addr_hi) addr_oob <= 1'b1;
        end
    end

    if (READ_LAT == 0) begin : g_async
        assign drv_ok   = drv_base;
        assign drv_ub   = ~SRAM_UB_N;
        assign drv_lb   = ~SRAM_LB_N;
        assign drv_data = rd_word;
    end else begin : g_pipe
        logic [READ_LAT-1:0] p_vld;
        logic [READ_LAT-1:0] p_ub;
        logic [READ_LAT-1:0] p_lb;
        logic [15:0]         p_dat [READ_LAT];

        // Data is captured at issue, so later writes never disturb in-flight reads.
        always_ff @(posedge clk) begin
            if (!rst) begin
                p_vld <= '0;
            end else begin
                p_vld[0] <= rd_cyc;
                for (int i = 1; i < READ_LAT; i++) p_vld[i] <= p_vld[i-1];
            end
        end

        always_ff @(posedge clk) begin
            p_dat[0] <= rd_word;
            p_ub[0]  <= ~SRAM_UB_N;
            p_lb[0]  <= ~SRAM_LB_N;
            for (int i = 1; i < READ_LAT; i++) begin
                p_dat[i] <= p_dat[i-1];
                p_ub[i]  <= p_ub[i-1];
                p_lb[i]  <= p_lb[i-1];
            end
        end

        assign drv_ok   = drv_base & p_vld[READ_LAT-1];
        assign drv_ub   = p_ub[READ_LAT-1];
        assign drv_lb   = p_lb[READ_LAT-1];
        assign drv_data = p_dat[READ_LAT-1];
    end

    assign SRAM_DQ[15:8] = (drv_ok & drv_ub) ? drv_data[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (drv_ok & drv_lb) ? drv_data[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: drives one async-read and one 2-clock-latency responder with identical bus traffic.
// DQ nets are pulled up, so an undriven byte reads back as 8'hFF.
module tb_sram_responder;

    localparam int AW = 4;
    localparam int NW = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce_n, we_n, oe_n, ub_n, lb_n, tb_drv;
    logic [17:0] addr;
    logic [15:0] tb_dat;
    tri1  [15:0] dq0;
    tri1  [15:0] dq2;
    logic [15:0] wr0, rd0, wr2, rd2;
    logic        oob0, oob2, busy0, busy2;

    assign dq0 = tb_drv ? tb_dat : 16'hzzzz;
    assign dq2 = tb_drv ? tb_dat : 16'hzzzz;

    sram_responder #(.MEM_AW(AW), .READ_LAT(0), .CNT_W(16)) u_lat0 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq0),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .wr_count(wr0), .rd_count(rd0), .addr_oob(oob0), .init_busy(busy0)
    );

    sram_responder #(.MEM_AW(AW), .READ_LAT(2), .CNT_W(16)) u_lat2 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq2),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .wr_count(wr2), .rd_count(rd2), .addr_oob(oob2), .init_busy(busy2)
    );

    // Reference model: memory array, counters, and a per-edge log of read issues.
    typedef struct packed {
        logic        vld;
        logic [15:0] dat;
        logic        ub;
        logic        lb;
    } rd_ent_t;

    logic [15:0] m_mem [NW];
    logic [15:0] m_wr, m_rd;
    logic        m_oob;
    int          m_clear_left;
    rd_ent_t     m_log[$];
    int          n_checks, n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        rd_ent_t       e;
        logic [AW-1:0] a;
        logic [15:0]   wd;
        e  = '0;
        a  = addr[AW-1:0];
        wd = tb_drv ? tb_dat : 16'hFFFF;
        if (!rst) begin
            m_wr  = '0;
            m_rd  = '0;
            m_oob = 1'b0;
            foreach (m_log[i]) m_log[i].vld = 1'b0;
`ifdef SRAM_RESP_CLEAR_EN
            m_clear_left = NW;
`endif
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
        end else if (!ce_n) begin
            if (addr[17:AW] != '0) m_oob = 1'b1;
            if (!we_n) begin
                m_wr = m_wr + 16'd1;
                if (!ub_n) m_mem[a][15:8] = wd[15:8];
                if (!lb_n) m_mem[a][7:0]  = wd[7:0];
            end else begin
                m_rd  = m_rd + 16'd1;
                e.vld = 1'b1;
                e.dat = m_mem[a];
                e.ub  = ~ub_n;
                e.lb  = ~lb_n;
            end
        end
        m_log.push_back(e);
        if (m_log.size() > 4) void'(m_log.pop_front());
    endtask

    task automatic check_outputs();
        logic [15:0] e0, e2;
        logic        base;
        rd_ent_t     ent;
        chk("wr_count0", 32'(wr0), 32'(m_wr));
        chk("wr_count2", 32'(wr2), 32'(m_wr));
        chk("rd_count0", 32'(rd0), 32'(m_rd));
        chk("rd_count2", 32'(rd2), 32'(m_rd));
        chk("addr_oob0", 32'(oob0), 32'(m_oob));
        chk("addr_oob2", 32'(oob2), 32'(m_oob));
        chk("init_busy0", 32'(busy0), 32'(m_clear_left > 0));
        chk("init_busy2", 32'(busy2), 32'(m_clear_left > 0));
        if (rst) begin
            base = ~ce_n & we_n & ~oe_n & (m_clear_left == 0);
            ent  = (m_log.size() >= 2) ? m_log[m_log.size()-2] : '0;
            e0   = 16'hFFFF;
            e2   = 16'hFFFF;
            if (tb_drv) begin
                e0 = tb_dat;
                e2 = tb_dat;
            end else begin
                if (base && !ub_n) e0[15:8] = m_mem[addr[AW-1:0]][15:8];
                if (base && !lb_n) e0[7:0]  = m_mem[addr[AW-1:0]][7:0];
                if (base && ent.vld && ent.ub) e2[15:8] = ent.dat[15:8];
                if (base && ent.vld && ent.lb) e2[7:0]  = ent.dat[7:0];
            end
            chk("dq_lat0", 32'(dq0), 32'(e0));
            chk("dq_lat2", 32'(dq2), 32'(e2));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic c, input logic w, input logic o, input logic [17:0] a,
                         input logic u, input logic l, input logic [15:0] d);
        ce_n   = c;
        we_n   = w;
        oe_n   = o;
        addr   = a;
        ub_n   = u;
        lb_n   = l;
        tb_dat = d;
        tb_drv = ~c & ~w;
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic u, input logic l);
        drive(1'b0, 1'b0, 1'b1, a, u, l, d);
        tick();
    endtask

    task automatic rd_set(input logic [17:0] a, input logic u, input logic l);
        drive(1'b0, 1'b1, 1'b0, a, u, l, 16'h0000);
        #1;
    endtask

    // Holds a write attempt on the bus for as long as the DUT reports the sweep.
    task automatic settle_clear();
        int n;
        n = 0;
        while (busy0 && n < 64) begin
            drive(1'b0, 1'b0, 1'b1, 18'h2, 1'b0, 1'b0, 16'h5555);
            tick();
            n++;
        end
`ifdef SRAM_RESP_CLEAR_EN
        chk("clear_len", 32'(n), 32'(NW));
`endif
        drive(1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic pulse_reset();
        drive(1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 1'b0, 16'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lo, hi;
        logic [17:0] a;
        n_checks     = 0;
        n_errors     = 0;
        m_clear_left = 0;
        m_wr         = '0;
        m_rd         = '0;
        m_oob        = 1'b0;
        rst          = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 1'b0, 16'h0);
        tick();
        tick();
        rst = 1'b1;
        settle_clear();
        chk("rst_wr_count", 32'(wr0), 32'd0);
        chk("rst_rd_count", 32'(rd0), 32'd0);
        chk("rst_oob", 32'(oob0), 32'd0);

        // Byte-lane write onto an existing word.
        wr(18'd5, 16'h1234, 1'b0, 1'b0);
        wr(18'd5, 16'hBEEF, 1'b0, 1'b1);
        chk("lane_wr_count", 32'(wr0), 32'd2);
        rd_set(18'd5, 1'b0, 1'b0);
        chk("lane_rd", 32'(dq0), 32'h0000BE34);
        tick();

        for (int i = 0; i < NW; i++)
            if (i != 5) wr(18'(i), 16'($urandom), 1'b0, 1'b0);

        // Two-clock read latency; a write behind the read must not alter it.
        wr(18'd3, 16'hA5A5, 1'b0, 1'b0);
        rd_set(18'd3, 1'b0, 1'b0);
        chk("lat_clk1_z", 32'(dq2), 32'h0000FFFF);
        tick();
        chk("lat_clk2_z", 32'(dq2), 32'h0000FFFF);
        wr(18'd3, 16'h0000, 1'b0, 1'b0);
        rd_set(18'd3, 1'b0, 1'b0);
        chk("lat_clk3_data", 32'(dq2), 32'h0000A5A5);
        chk("lat_wr_landed", 32'(dq0), 32'h00000000);
        tick();

        // Tristate rules.
        drive(1'b0, 1'b1, 1'b1, 18'd5, 1'b0, 1'b0, 16'h0);
        #1;
        chk("oe_high_z", 32'(dq0), 32'h0000FFFF);
        drive(1'b0, 1'b0, 1'b0, 18'd5, 1'b0, 1'b0, 16'h0);
        tb_drv = 1'b0;
        #1;
        chk("we_low_z", 32'(dq0), 32'h0000FFFF);
        rd_set(18'd5, 1'b1, 1'b0);
        chk("ub_masked", 32'(dq0), 32'h0000FF34);
        tick();

        // Aliasing and sticky out-of-range flag.
        wr(18'h00405, 16'h7777, 1'b0, 1'b0);
        chk("oob_set", 32'(oob0), 32'd1);
        rd_set(18'h00005, 1'b0, 1'b0);
        chk("alias_rd", 32'(dq0), 32'h00007777);
        tick();
        pulse_reset();
        chk("rst_clears_oob", 32'(oob0), 32'd0);
        chk("rst_clears_wr", 32'(wr0), 32'd0);
        rd_set(18'h00005, 1'b0, 1'b0);
`ifdef SRAM_RESP_CLEAR_EN
        chk("data_after_rst", 32'(dq0), 32'h00000000);
`else
        chk("data_after_rst", 32'(dq0), 32'h00007777);
`endif
        tick();

        // Controller-style 32-bit store and load across two words.
        wr(18'd8, 16'hF00D, 1'b0, 1'b0);
        wr(18'd9, 16'hCAFE, 1'b0, 1'b0);
        rd_set(18'd8, 1'b0, 1'b0);
        lo = dq0;
        tick();
        rd_set(18'd9, 1'b0, 1'b0);
        hi = dq0;
        tick();
        chk("ctl_dword", {hi, lo}, 32'hCAFEF00D);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                pulse_reset();
            end else begin
                a = 18'($urandom_range(0, NW - 1));
                if ($urandom_range(0, 15) == 0) a[17:AW] = 14'($urandom_range(1, 16383));
                drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 5) == 0), a, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
